// File: rtl/ram_delay_pkg.sv
// Shared definitions for the ram_delay read-side blocks: default widths and
// the boxcar state encoding.
package ram_delay_pkg;

    localparam int unsigned NBITS_DATA = 42;
    localparam int unsigned NBITS_ADDR = 9;
    localparam int unsigned SUM_SHIFT  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/ram_delay_sum.sv
// Boxcar moving-sum over the last n samples delivered by ram_delay. It adds the
// newest sample and subtracts the one leaving the window, one result per valid.
module ram_delay_sum
    import ram_delay_pkg::*;
#(
    parameter int P_NBITS_DATA = NBITS_DATA,
    parameter int P_NBITS_ADDR = NBITS_ADDR,
    parameter int P_NBITS_SUM  = P_NBITS_DATA + P_NBITS_ADDR,
    parameter int P_SHIFT      = SUM_SHIFT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [P_NBITS_ADDR-1:0]       n,
    input  logic                          flush,
    input  logic                          valid,
    input  logic [P_NBITS_DATA-1:0]       qn,
    input  logic [P_NBITS_DATA-1:0]       qo,
    output logic [P_NBITS_SUM-1:0]        sum,
    output logic [P_NBITS_SUM-P_SHIFT-1:0] mean,
    output logic                          sum_valid,
    output logic                          filling,
    output logic [P_NBITS_ADDR-1:0]       fill_cnt
);

    localparam logic [P_NBITS_ADDR-1:0] L_ONE = 1;

    state_t                    r_state, w_state_nxt;
    logic [P_NBITS_ADDR-1:0]   r_n_q;
    logic [P_NBITS_ADDR-1:0]   r_fill_cnt, w_cnt_nxt;
    logic                      r_sum_valid, w_sv_nxt;
    logic [P_NBITS_SUM-1:0]    r_sum;
    logic [P_NBITS_SUM-1:0]    w_qn, w_qo;
    logic                      w_restart;
    logic                      w_acc_clr, w_acc_add, w_acc_run;

    // A new window length invalidates everything accumulated so far.
    assign w_restart = flush | (n != r_n_q);
    assign w_qn      = P_NBITS_SUM'(qn);
    assign w_qo      = P_NBITS_SUM'(qo);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_fill_cnt;
        w_sv_nxt    = 1'b0;
        w_acc_clr   = 1'b0;
        w_acc_add   = 1'b0;
        w_acc_run   = 1'b0;
        if (w_restart) begin
            w_acc_clr   = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = (n == '0) ? IDLE : FILL;
        end else begin
            case (r_state)
                FILL: if (valid) begin
                    w_acc_add = 1'b1;
                    w_cnt_nxt = r_fill_cnt + L_ONE;
                    if (r_fill_cnt == n - L_ONE) begin
                        w_state_nxt = RUN;
                        w_sv_nxt    = 1'b1;
                    end
                end
                RUN: if (valid) begin
                    w_acc_run = 1'b1;
                    w_sv_nxt  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_n_q       <= '0;
            r_fill_cnt  <= '0;
            r_sum_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_n_q       <= n;
            r_fill_cnt  <= w_cnt_nxt;
            r_sum_valid <= w_sv_nxt;
        end
    end

    // Width is sized so the full-scale window never wraps; subtraction in RUN
    // relies on modulo arithmetic only for the intermediate add.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= '0;
        end else if (w_acc_clr) begin
            r_sum <= '0;
        end else if (w_acc_add) begin
            r_sum <= r_sum + w_qn;
        end else if (w_acc_run) begin
            r_sum <= r_sum + w_qn - w_qo;
        end
    end

    assign sum       = r_sum;
    assign mean      = r_sum[P_NBITS_SUM-1:P_SHIFT];
    assign sum_valid = r_sum_valid;
    assign filling   = (r_state != RUN);
    assign fill_cnt  = r_fill_cnt;

endmodule

// File: tb/tb_ram_delay_sum.sv
// Directed bench for ram_delay_sum: fill/run sums, gaps, flush, n changes,
// n=1, full-scale window and asynchronous reset.
module tb_ram_delay_sum;

    localparam int DW = 42;
    localparam int AW = 9;
    localparam int SW = DW + AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] n;
    logic          flush;
    logic          valid;
    logic [DW-1:0] qn, qo;
    logic [SW-1:0] sum;
    logic [SW-5:0] mean;
    logic          sum_valid;
    logic          filling;
    logic [AW-1:0] fill_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    ram_delay_sum dut (
        .clk(clk), .rst_n(rst_n), .n(n), .flush(flush), .valid(valid),
        .qn(qn), .qo(qo), .sum(sum), .mean(mean), .sum_valid(sum_valid),
        .filling(filling), .fill_cnt(fill_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b);
        valid = v; qn = a; qo = b;
    endtask

    task automatic test_reset();
        n_tests++; if (sum !== '0) begin n_fail++; $display("FAIL reset_sum got %0d want 0", sum); end
        n_tests++; if (sum_valid !== 1'b0) begin n_fail++; $display("FAIL reset_sv got %b want 0", sum_valid); end
        n_tests++; if (fill_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", fill_cnt); end
        n_tests++; if (filling !== 1'b1) begin n_fail++; $display("FAIL reset_filling got %b want 1", filling); end
        rst_n = 1'b1;
        tick();  // n-change restart: enters FILL
        n_tests++; if (filling !== 1'b1 || fill_cnt !== '0) begin n_fail++; $display("FAIL post_reset filling=%b cnt=%0d want 1/0", filling, fill_cnt); end
    endtask

    task automatic test_fill_run();
        int exp_sum [7] = '{1, 3, 6, 10, 14, 18, 22};
        for (int k = 1; k <= 7; k++) begin
            drive(1'b1, DW'(k), (k > 4) ? DW'(k - 4) : '0);
            tick();
            n_tests++; if (sum_valid !== (k >= 4)) begin n_fail++; $display("FAIL fill_sv k=%0d got %b want %b", k, sum_valid, k >= 4); end
            n_tests++; if (sum !== SW'(exp_sum[k-1])) begin n_fail++; $display("FAIL fill_sum k=%0d got %0d want %0d", k, sum, exp_sum[k-1]); end
        end
        n_tests++; if (fill_cnt !== 9'd4 || filling !== 1'b0) begin n_fail++; $display("FAIL run_cnt cnt=%0d filling=%b want 4/0", fill_cnt, filling); end
        drive(1'b0, '0, '0);
        tick();
        n_tests++; if (sum_valid !== 1'b0 || sum !== 51'd22) begin n_fail++; $display("FAIL idle_hold sv=%b sum=%0d want 0/22", sum_valid, sum); end
    endtask

    task automatic test_gapped();
        int exp_sum [7] = '{1, 3, 6, 10, 14, 18, 22};
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_tests++; if (sum !== '0 || filling !== 1'b1) begin n_fail++; $display("FAIL gap_flush sum=%0d filling=%b want 0/1", sum, filling); end
        for (int k = 1; k <= 7; k++) begin
            drive(1'b1, DW'(k), (k > 4) ? DW'(k - 4) : '0);
            tick();
            drive(1'b0, '0, '0);
            n_tests++; if (sum_valid !== (k >= 4) || sum !== SW'(exp_sum[k-1])) begin n_fail++; $display("FAIL gap_sum k=%0d got sv=%b sum=%0d want sv=%b sum=%0d", k, sum_valid, sum, k >= 4, exp_sum[k-1]); end
            for (int g = 0; g < 2; g++) begin
                tick();
                n_tests++; if (sum_valid !== 1'b0 || sum !== SW'(exp_sum[k-1])) begin n_fail++; $display("FAIL gap_hole k=%0d got sv=%b sum=%0d", k, sum_valid, sum); end
            end
        end
    endtask

    task automatic test_flush_valid();
        flush = 1'b1;
        drive(1'b1, 42'd100, 42'd3);
        tick();
        flush = 1'b0;
        drive(1'b0, '0, '0);
        n_tests++; if (sum !== '0 || filling !== 1'b1 || fill_cnt !== '0 || sum_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drop sum=%0d filling=%b cnt=%0d sv=%b want 0/1/0/0", sum, filling, fill_cnt, sum_valid); end
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 42'd9, '0);
            tick();
            n_tests++; if (sum_valid !== (k == 4) || sum !== SW'(9 * k)) begin n_fail++; $display("FAIL flush_refill k=%0d sv=%b sum=%0d want %b/%0d", k, sum_valid, sum, k == 4, 9 * k); end
        end
    endtask

    task automatic test_n_change();
        n = 9'd2;
        drive(1'b1, 42'd50, 42'd9);
        tick();
        n_tests++; if (sum !== '0 || fill_cnt !== '0 || filling !== 1'b1 || sum_valid !== 1'b0) begin n_fail++; $display("FAIL nchg_restart sum=%0d cnt=%0d filling=%b sv=%b", sum, fill_cnt, filling, sum_valid); end
        drive(1'b1, 42'd5, '0);
        tick();
        n_tests++; if (sum_valid !== 1'b0 || sum !== 51'd5) begin n_fail++; $display("FAIL nchg_s1 sv=%b sum=%0d want 0/5", sum_valid, sum); end
        drive(1'b1, 42'd7, '0);
        tick();
        n_tests++; if (sum_valid !== 1'b1 || sum !== 51'd12) begin n_fail++; $display("FAIL nchg_s2 sv=%b sum=%0d want 1/12", sum_valid, sum); end
        n = '0;
        drive(1'b0, '0, '0);
        tick();
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 42'd3, 42'd1);
            tick();
            n_tests++; if (sum_valid !== 1'b0 || sum !== '0 || filling !== 1'b1 || fill_cnt !== '0) begin n_fail++; $display("FAIL n0_idle k=%0d sv=%b sum=%0d filling=%b cnt=%0d", k, sum_valid, sum, filling, fill_cnt); end
        end
    endtask

    task automatic test_n_one();
        n = 9'd1;
        drive(1'b0, '0, '0);
        tick();
        drive(1'b1, 42'd5, '0);
        tick();
        n_tests++; if (sum_valid !== 1'b1 || sum !== 51'd5 || fill_cnt !== 9'd1) begin n_fail++; $display("FAIL n1_first sv=%b sum=%0d cnt=%0d want 1/5/1", sum_valid, sum, fill_cnt); end
        drive(1'b1, 42'd8, 42'd5);
        tick();
        n_tests++; if (sum_valid !== 1'b1 || sum !== 51'd8) begin n_fail++; $display("FAIL n1_run sv=%b sum=%0d want 1/8", sum_valid, sum); end
    endtask

    task automatic test_full_scale();
        logic [DW-1:0] mx;
        logic [SW-1:0] exp_full;
        mx       = '1;
        exp_full = 51'd511 * {9'd0, mx};
        n = 9'd511;
        drive(1'b0, '0, '0);
        tick();
        for (int i = 0; i < 511; i++) begin
            drive(1'b1, mx, mx);
            tick();
            if (i < 510) begin
                n_tests++; if (sum_valid !== 1'b0) begin n_fail++; $display("FAIL fs_fill i=%0d sv=%b want 0", i, sum_valid); end
            end
        end
        n_tests++; if (sum_valid !== 1'b1 || sum !== exp_full) begin n_fail++; $display("FAIL fs_sum sv=%b sum=%0h want 1/%0h", sum_valid, sum, exp_full); end
        n_tests++; if (mean !== exp_full[SW-1:4]) begin n_fail++; $display("FAIL fs_mean got %0h want %0h", mean, exp_full[SW-1:4]); end
        n_tests++; if (fill_cnt !== 9'd511 || filling !== 1'b0) begin n_fail++; $display("FAIL fs_cnt cnt=%0d filling=%b want 511/0", fill_cnt, filling); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++; if (sum_valid !== 1'b1 || sum !== exp_full || fill_cnt !== 9'd511) begin n_fail++; $display("FAIL fs_hold i=%0d sv=%b sum=%0h cnt=%0d", i, sum_valid, sum, fill_cnt); end
        end
    endtask

    task automatic test_reset_mid_run();
        drive(1'b0, '0, '0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        n = 9'd4;
        #1;
        n_tests++; if (sum !== '0 || sum_valid !== 1'b0 || fill_cnt !== '0 || filling !== 1'b1) begin n_fail++; $display("FAIL async_rst sum=%0d sv=%b cnt=%0d filling=%b want 0/0/0/1", sum, sum_valid, fill_cnt, filling); end
        tick();
        rst_n = 1'b1;
        tick();
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, DW'(k), '0);
            tick();
            n_tests++; if (sum_valid !== (k == 4)) begin n_fail++; $display("FAIL rst_refill k=%0d sv=%b want %b", k, sum_valid, k == 4); end
        end
        n_tests++; if (sum !== 51'd10) begin n_fail++; $display("FAIL rst_refill_sum got %0d want 10", sum); end
        drive(1'b0, '0, '0);
    endtask

    initial begin
        rst_n = 1'b0;
        n     = 9'd4;
        flush = 1'b0;
        drive(1'b0, '0, '0);
        tick();
        tick();
        test_reset();
        test_fill_run();
        test_gapped();
        test_flush_valid();
        test_n_change();
        test_n_one();
        test_full_scale();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_delay_sum.md
Name: ram_delay_sum

Overview:
- Boxcar (moving-sum) engine on the read side of ram_delay.
- Consumes the per-write qn (newest) / qo (n-samples-old) pair and valid strobe from ram_delay.
- Maintains a running sum over the last n samples and emits it with a valid pulse.
- Tracks window fill, and restarts on flush or on a change of n.

Parameters:
- P_NBITS_DATA, 42, width of qn/qo samples (unsigned).
- P_NBITS_ADDR, 9, width of n; max window 2^P_NBITS_ADDR-1.
- P_NBITS_SUM, P_NBITS_DATA+P_NBITS_ADDR, accumulator width; cannot overflow for unsigned inputs.
- P_SHIFT, 4, right shift applied to sum to form mean.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- n, in, P_NBITS_ADDR, window length; same value driven to ram_delay.
- flush, in, 1, synchronous restart of the window.
- valid, in, 1, ram_delay output strobe; qn/qo valid this cycle.
- qn, in, P_NBITS_DATA, newest sample.
- qo, in, P_NBITS_DATA, sample leaving the window (written n valids earlier).
- sum, out, P_NBITS_SUM, registered window sum.
- mean, out, P_NBITS_SUM-P_SHIFT, sum >> P_SHIFT, combinational from the sum register.
- sum_valid, out, 1, one-cycle pulse; sum is a full-window result.
- filling, out, 1, high while the window is not yet full.
- fill_cnt, out, P_NBITS_ADDR, samples accumulated since last restart.

Behaviour:
- Reset (rst_n=0, async): sum=0, sum_valid=0, fill_cnt=0, state=IDLE, filling=1, n_q=0.
- States:
  - IDLE: n==0.
  - FILL: window not yet full.
  - RUN: window full.
- n_q is a registered copy of n. n != n_q in any cycle is treated exactly as flush; n_q updates that cycle.
- Priority, highest first: rst_n, then flush/n-change, then valid.
- Restart (flush or n-change): sum=0, fill_cnt=0, sum_valid=0. Next state is IDLE if the new n==0, else FILL. A valid coincident with restart is dropped.
- IDLE: ignore valid. Go to FILL when n becomes non-zero (via the n-change restart).
- FILL, on valid:
  - sum <= sum + qn; fill_cnt++.
  - If fill_cnt == n-1 (this is the n-th sample): state <= RUN, sum_valid <= 1 next cycle, filling <= 0.
  - Otherwise sum_valid stays 0.
- RUN, on valid: sum <= sum + qn - qo, computed in P_NBITS_SUM modulo arithmetic as a single expression; sum_valid <= 1. fill_cnt holds at n.
- No valid in FILL/RUN: hold all state; sum_valid=0.
- Latency: sum/sum_valid are registered 1 cycle after the qualifying valid. Back-to-back valids give back-to-back sum_valid pulses; no stall, full throughput.
- n==1: first sample completes fill (sum=qn). Thereafter sum = sum + qn - qo.
- fill_cnt saturates at n. filling = (state != RUN).
- mean is pure truncation; no rounding.

Decomposition:
- Package ram_delay_pkg: state encoding (IDLE=2'd0, FILL=2'd1, RUN=2'd2), default widths shared with ram_delay.
- No sub-module. A single always block for the state/counter, plus a separate accumulator datapath.

Test Plan:
- Reset mid-RUN: n=4 running, assert rst_n=0 asynchronously between edges → sum=0, sum_valid=0, fill_cnt=0 immediately. After release, refill is required before sum_valid.
- Fill then run: n=4, valid stream qn=1,2,3,…, qo=qn-4 once full → no sum_valid for samples 1–3. sum_valid with sum=10 one cycle after sample 4, then 14, 18, 22 on consecutive pulses.
- Gapped valids: same stream with valid every 3rd cycle → same sum sequence 10,14,18. Each sum_valid lands exactly one cycle after its valid; nothing in the gaps.
- Flush with coincident valid: in RUN with sum=22, assert flush+valid → sample dropped, sum=0, filling=1. Next 4 samples 9,9,9,9 give sum=36.
- n change and n=0: change n 4→2 mid-RUN → restart; samples 5,7 give sum=12. Set n=0 → IDLE; 10 valids produce no sum_valid and sum stays 0.
- Full-scale: n=511, qn=qo=2^42-1 every cycle → after fill, sum=511·(2^42-1) with no wrap. mean = sum>>4. sum stays constant in RUN.
